// File: rtl/ercm_pkg.sv
// Shared types and constants for the ercm_pipe_mult pipelined approximate multiplier.
package ercm_pkg;

  localparam int unsigned MAX_W    = 16;
  localparam int unsigned MAX_COLS = 2 * MAX_W;
  localparam int unsigned CSUM_W   = 5;
  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  // S1 payload: operands carried as their partial-product matrix, plus mode
  typedef struct packed {
    logic                           approx;
    logic [MAX_W-1:0][MAX_W-1:0]    pp;
  } ercm_s1_t;

  // S2 payload: per-column partial sums, mode and compensation request
  typedef struct packed {
    logic                           approx;
    logic [MAX_COLS-1:0][CSUM_W-1:0] csum;
    logic                           comp;
  } ercm_s2_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ercm_col_compress.sv
// One product column: OR-reduce in the approximate region, popcount elsewhere,
// plus the compensation flag when this is the top approximate column.
module ercm_col_compress
  import ercm_pkg::*;
#(
  parameter int unsigned N_BITS   = MAX_W,
  parameter int unsigned SUM_W    = CSUM_W,
  parameter bit          COMP_COL = 1'b0
) (
  input  logic [N_BITS-1:0] i_bits,
  input  logic              i_approx,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_comp
);

  logic [SUM_W-1:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < N_BITS; i++) begin
      w_cnt = w_cnt + SUM_W'(i_bits[i]);
    end
  end

  assign o_sum = i_approx ? SUM_W'(|i_bits) : w_cnt;

  generate
    if (COMP_COL) begin : g_comp
      assign o_comp = i_approx && (w_cnt > SUM_W'(1));
    end else begin : g_nocomp
      assign o_comp = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ercm_pipe_mult.sv
// Three-stage valid/ready multiplier with per-transaction exact/approximate mode.
// Optional error compensation enabled by defining ERCM_ERR_COMP_EN.
module ercm_pipe_mult
  import ercm_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int          APPROX_COLS = int'(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   dat_in_a,
  input  logic [WIDTH-1:0]   dat_in_b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dat_o,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int unsigned PW = 2 * WIDTH;

`ifdef ERCM_ERR_COMP_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif

  logic                             r_v1, r_v2, r_v3;
  ercm_s1_t                         r_s1, w_s1_d;
  ercm_s2_t                         r_s2, w_s2_d;
  logic [PW-1:0]                    r_res, w_sum;
  logic                             r_apx3;
  logic [CNT_W-1:0]                 r_cnt;
  logic                             w_s3_free, w_adv2, w_s2_free, w_adv1, w_acc;
  logic [MAX_W-1:0]                 w_a, w_b;
  logic [MAX_COLS-1:0][CSUM_W-1:0]  w_csum;
  logic [MAX_COLS-1:0]              w_comp;

  // Backward-propagating advance chain so bubbles collapse
  assign w_s3_free = !r_v3 || out_ready;
  assign w_adv2    = r_v2 && w_s3_free;
  assign w_s2_free = !r_v2 || w_adv2;
  assign w_adv1    = r_v1 && w_s2_free;
  assign in_ready  = rst_n && (!r_v1 || w_adv1);
  assign w_acc     = in_valid && in_ready;

  assign w_a = MAX_W'(dat_in_a);
  assign w_b = MAX_W'(dat_in_b);

  always_comb begin
    w_s1_d.approx = approx_en;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      for (int unsigned j = 0; j < MAX_W; j++) begin
        w_s1_d.pp[i][j] = w_a[i] & w_b[j];
      end
    end
  end

  // Gather the anti-diagonal i+j == c of the partial-product matrix per column
  for (genvar c = 0; c < int'(MAX_COLS); c++) begin : g_col
    logic [MAX_W-1:0] w_bits;
    for (genvar i = 0; i < int'(MAX_W); i++) begin : g_bit
      if ((c >= i) && ((c - i) < int'(MAX_W))) begin : g_on
        assign w_bits[i] = r_s1.pp[i][c-i];
      end else begin : g_off
        assign w_bits[i] = 1'b0;
      end
    end
    ercm_col_compress #(
      .N_BITS  (MAX_W),
      .SUM_W   (CSUM_W),
      .COMP_COL(COMP_EN && (c == APPROX_COLS - 1))
    ) u_col (
      .i_bits  (w_bits),
      .i_approx(r_s1.approx && (c < APPROX_COLS)),
      .o_sum   (w_csum[c]),
      .o_comp  (w_comp[c])
    );
  end

  always_comb begin
    w_s2_d.approx = r_s1.approx;
    w_s2_d.csum   = w_csum;
    w_s2_d.comp   = |w_comp;
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned c = 0; c < MAX_COLS; c++) begin
      w_sum = w_sum + (PW'(r_s2.csum[c]) << c);
    end
    w_sum = w_sum + (PW'(r_s2.comp) << APPROX_COLS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_res  <= '0;
      r_apx3 <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_v1 <= w_acc  || (r_v1 && !w_adv1);
      r_v2 <= w_adv1 || (r_v2 && !w_adv2);
      r_v3 <= w_adv2 || (r_v3 && !out_ready);
      if (w_adv2) begin
        r_res  <= w_sum;
        r_apx3 <= r_s2.approx;
      end
      if (r_v3 && out_ready && r_apx3) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_s1 <= w_s1_d;
    end
    if (w_adv1) begin
      r_s2 <= w_s2_d;
    end
  end

  assign out_valid  = r_v3;
  assign dat_o      = r_res;
  assign approx_cnt = r_cnt;

endmodule

// File: tb/tb_ercm_pipe_mult.sv
// Scoreboard bench for ercm_pipe_mult (WIDTH=8, APPROX_COLS=8); honours ERCM_ERR_COMP_EN.
module tb_ercm_pipe_mult;

  localparam int W  = 8;
  localparam int AC = 8;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] res;
    bit            apx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          approx_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dat_in_a = '0;
  logic [W-1:0]  dat_in_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] dat_o;
  logic [15:0]   approx_cnt;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  exp_t sb[$];

  ercm_pipe_mult #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat_in_a  (dat_in_a),
    .dat_in_b  (dat_in_b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dat_o     (dat_o),
    .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit apx);
    int            cnt[PW];
    int            hi;
    logic [PW-1:0] r;
    if (!apx) begin
      r = {8'b0, a} * {8'b0, b};
      return r;
    end
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j]) cnt[i+j]++;
    r  = '0;
    hi = 0;
    for (int c = 0; c < PW; c++) begin
      if (c < AC) begin
        if (cnt[c] > 0) r[c] = 1'b1;
      end else begin
        hi += cnt[c] << c;
      end
    end
`ifdef ERCM_ERR_COMP_EN
    if (cnt[AC-1] >= 2) hi += 1 << AC;
`endif
    r = r + hi[PW-1:0];
    return r;
  endfunction

  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input bit apx,
                          input logic [PW-1:0] req, input string name);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; dat_in_a = a; dat_in_b = b; approx_en = apx; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 12) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL %s_latency: got %0d cycles expected 3", name, lat);
    end
    checks++;
    if (dat_o !== req) begin
      errors++; $display("FAIL %s_data: got 0x%0h expected 0x%0h", name, dat_o, req);
    end
    if (apx && exp_cnt < 65535) exp_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (approx_cnt !== exp_cnt[15:0]) begin
      errors++; $display("FAIL %s_cnt: got %0d expected %0d", name, approx_cnt, exp_cnt);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_drain: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (dat_o !== '0) begin errors++; $display("FAIL rst_dat_o: got 0x%0h expected 0", dat_o); end
    checks++;
    if (approx_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", approx_cnt); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [PW-1:0] ff_apx;
`ifdef ERCM_ERR_COMP_EN
    ff_apx = 16'hF8FF;
`else
    ff_apx = 16'hF7FF;
`endif
    send_one(8'd255, 8'd255, 1'b0, 16'd65025, "exact_ff");
    send_one(8'd255, 8'd255, 1'b1, ff_apx, "approx_ff");
    checks++;
    if (approx_cnt !== 16'd1) begin errors++; $display("FAIL approx_ff_cnt1: got %0d expected 1", approx_cnt); end
    send_one(8'd3, 8'd5, 1'b1, 16'd15, "approx_3x5");
    send_one(8'd3, 8'd3, 1'b1, 16'd7, "approx_3x3");
    send_one(8'd128, 8'd3, 1'b1, 16'h0180, "approx_edge_col");
    send_one(8'd0, 8'd200, 1'b1, 16'd0, "approx_zero");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    bit apx;
    for (int k = 0; k < 8; k++) begin
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      apx = k[0];
      send_one(a, b, apx, model(a, b, apx), "random");
    end
  endtask

  task automatic test_back_to_back();
    int           idx = 0;
    int           delivered = 0;
    int           cyc = 0;
    bit           stalled_prev = 1'b0;
    bit           exp_rdy;
    logic [PW-1:0] held = '0;
    logic [W-1:0] a, b;
    exp_t         e;
    sb.delete();
    while (delivered < 10 && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (idx < 10) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        in_valid = 1'b1; dat_in_a = a; dat_in_b = b; approx_en = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      exp_rdy = out_ready || (sb.size() < 3);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL stream_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy);
      end
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || dat_o !== held) begin
          errors++; $display("FAIL stream_hold cyc%0d: got v=%b 0x%0h expected v=1 0x%0h", cyc, out_valid, dat_o, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc%0d: got 0x%0h expected no output", cyc, dat_o);
        end else begin
          e = sb.pop_front();
          if (dat_o !== e.res) begin
            errors++; $display("FAIL stream_data cyc%0d: got 0x%0h expected 0x%0h", cyc, dat_o, e.res);
          end
          if (e.apx && exp_cnt < 65535) exp_cnt++;
        end
        delivered++;
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      held = dat_o;
      if (in_valid && in_ready === 1'b1) begin
        e.res = model(dat_in_a, dat_in_b, approx_en);
        e.apx = approx_en;
        sb.push_back(e);
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (delivered != 10 || sb.size() != 0) begin
      errors++; $display("FAIL stream_count: got %0d delivered, %0d pending expected 10, 0", delivered, sb.size());
    end
    @(negedge clk);
    checks++;
    if (approx_cnt !== exp_cnt[15:0]) begin
      errors++; $display("FAIL stream_cnt: got %0d expected %0d", approx_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; dat_in_a = W'(k + 5); dat_in_b = 8'd7; approx_en = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b expected 1", out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL inflight_rst_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL inflight_discard cyc%0d: got %b expected 0", k, out_valid); end
    end
    checks++;
    if (approx_cnt !== 16'd0) begin errors++; $display("FAIL inflight_cnt: got %0d expected 0", approx_cnt); end
    send_one(8'd7, 8'd9, 1'b0, 16'd63, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
